// File: rtl/arm_v4.sv
// Single-cycle ARMv4 integer core: data processing, word LDR/STR, B/BL, all conditional.
// Register file, NZCV flags and PC update together on the rising edge; everything else is combinational.
module arm_v4 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] ReadData,
  output logic        MemWrite,
  output logic [31:0] PC,
  output logic [31:0] DataAddr,
  output logic [31:0] WriteData
);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_RSB = 4'b0011;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Entry 15 is never written; R15 reads are redirected to PC+8.
  logic [31:0] regs_q [16];
  logic [31:0] pc_q, pc_d;
  logic [3:0]  flags_q, flags_d;
  logic        reg_we;
  logic [3:0]  reg_wa;
  logic [31:0] reg_wd;
  logic        mem_we;

  logic [3:0]  cond, cmd, rn, rd, rm;
  logic [1:0]  op;
  logic        imm_sel, s_bit;
  logic [31:0] pc_plus4, pc_plus8;
  logic [31:0] rn_val, rm_val, rd_val;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_pass;

  assign cond    = Instruction[31:28];
  assign op      = Instruction[27:26];
  assign imm_sel = Instruction[25];
  assign cmd     = Instruction[24:21];
  assign s_bit   = Instruction[20];
  assign rn      = Instruction[19:16];
  assign rd      = Instruction[15:12];
  assign rm      = Instruction[3:0];

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign rn_val   = (rn == 4'hF) ? pc_plus8 : regs_q[rn];
  assign rm_val   = (rm == 4'hF) ? pc_plus8 : regs_q[rm];
  assign rd_val   = (rd == 4'hF) ? pc_plus8 : regs_q[rd];

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Operand 2: rotated immediate or immediate-shifted Rm.
  logic [4:0]  shamt, rot;
  logic [31:0] imm_ext, imm_rot, shifted, op2;

  assign shamt   = Instruction[11:7];
  assign rot     = {Instruction[11:8], 1'b0};
  assign imm_ext = {24'd0, Instruction[7:0]};
  assign imm_rot = (imm_ext >> rot) | (imm_ext << (6'd32 - {1'b0, rot}));

  always_comb begin
    shifted = rm_val;
    case (Instruction[6:5])
      2'b00: shifted = rm_val << shamt;
      2'b01: shifted = rm_val >> shamt;
      2'b10: shifted = $signed(rm_val) >>> shamt;
      2'b11: shifted = (rm_val >> shamt) | (rm_val << (6'd32 - {1'b0, shamt}));
      default: shifted = rm_val;
    endcase
  end

  assign op2 = imm_sel ? imm_rot : shifted;

  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        alu_arith, alu_v, dp_cmd_ok;

  always_comb begin
    sum       = 33'd0;
    alu_res   = 32'd0;
    alu_arith = 1'b0;
    alu_v     = 1'b0;
    dp_cmd_ok = 1'b1;
    case (cmd)
      CMD_AND: alu_res = rn_val & op2;
      CMD_EOR: alu_res = rn_val ^ op2;
      CMD_ORR: alu_res = rn_val | op2;
      CMD_MOV: alu_res = op2;
      CMD_SUB, CMD_CMP: begin
        sum       = {1'b0, rn_val} + {1'b0, ~op2} + 33'd1;
        alu_res   = sum[31:0];
        alu_arith = 1'b1;
        alu_v     = (rn_val[31] ^ op2[31]) & (alu_res[31] ^ rn_val[31]);
      end
      CMD_RSB: begin
        sum       = {1'b0, op2} + {1'b0, ~rn_val} + 33'd1;
        alu_res   = sum[31:0];
        alu_arith = 1'b1;
        alu_v     = (rn_val[31] ^ op2[31]) & (alu_res[31] ^ op2[31]);
      end
      CMD_ADD: begin
        sum       = {1'b0, rn_val} + {1'b0, op2};
        alu_res   = sum[31:0];
        alu_arith = 1'b1;
        alu_v     = ~(rn_val[31] ^ op2[31]) & (alu_res[31] ^ rn_val[31]);
      end
      default: dp_cmd_ok = 1'b0;
    endcase
  end

  logic        dp_ok, mem_ok;
  logic [31:0] mem_addr, br_target;

  assign dp_ok     = dp_cmd_ok && (imm_sel || !Instruction[4]);
  // Only pre-indexed, no-writeback, word, immediate-offset transfers are supported.
  assign mem_ok    = !imm_sel && Instruction[24] && !Instruction[22] && !Instruction[21];
  assign mem_addr  = Instruction[23] ? rn_val + {20'd0, Instruction[11:0]}
                                     : rn_val - {20'd0, Instruction[11:0]};
  assign br_target = pc_plus8 + {{6{Instruction[23]}}, Instruction[23:0], 2'b00};

  always_comb begin
    reg_we  = 1'b0;
    reg_wa  = rd;
    reg_wd  = alu_res;
    flags_d = flags_q;
    pc_d    = pc_plus4;
    mem_we  = 1'b0;
    if (cond_pass) begin
      case (op)
        2'b00: if (dp_ok) begin
          if (cmd != CMD_CMP) begin
            if (rd == 4'hF) pc_d = alu_res;
            else            reg_we = 1'b1;
          end
          if (s_bit || cmd == CMD_CMP)
            flags_d = {alu_res[31], alu_res == 32'd0,
                       alu_arith ? sum[32] : flag_c,
                       alu_arith ? alu_v   : flag_v};
        end
        2'b01: if (mem_ok) begin
          if (s_bit) begin
            reg_wd = ReadData;
            if (rd == 4'hF) pc_d = ReadData;
            else            reg_we = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
        2'b10: begin
          pc_d = br_target;
          if (Instruction[24]) begin
            reg_we = 1'b1;
            reg_wa = 4'd14;
            reg_wd = pc_plus4;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= 32'd0;
      flags_q <= 4'd0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      if (reg_we) regs_q[reg_wa] <= reg_wd;
    end
  end

  assign PC        = pc_q;
  assign DataAddr  = (op == 2'b01) ? mem_addr : alu_res;
  assign WriteData = rd_val;
  assign MemWrite  = mem_we && reset;

endmodule

// File: tb/tb_arm_v4.sv
// Directed program for arm_v4; results are observed through the memory port and PC.
module tb_arm_v4;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction;
  logic [31:0] ReadData;
  logic        MemWrite;
  logic [31:0] PC;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [64];

  arm_v4 dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .ReadData(ReadData),
    .MemWrite(MemWrite), .PC(PC), .DataAddr(DataAddr), .WriteData(WriteData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Instruction = imem[PC[7:2]];
  assign ReadData    = (DataAddr == 32'd4) ? 32'h0000_0023 : 32'h0000_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hE1A0_0000;
    imem[6'h00] = 32'hE3A00005; // MOV R0,#5
    imem[6'h01] = 32'hE2801003; // ADD R1,R0,#3
    imem[6'h02] = 32'hE5821014; // STR R1,[R2,#20]
    imem[6'h03] = 32'hE5923004; // LDR R3,[R2,#4]
    imem[6'h04] = 32'hE1A00003; // MOV R0,R3
    imem[6'h05] = 32'hE1530000; // CMP R3,R0
    imem[6'h06] = 32'h0A000001; // BEQ 0x24
    imem[6'h07] = 32'hE3A0500F;
    imem[6'h08] = 32'hE3A05010;
    imem[6'h09] = 32'hEB000000; // BL 0x2C
    imem[6'h0A] = 32'hE3A05001;
    imem[6'h0B] = 32'hE0504000; // SUBS R4,R0,R0
    imem[6'h0C] = 32'h15821000; // STRNE R1,[R2]
    imem[6'h0D] = 32'h1A000001; // BNE (not taken)
    imem[6'h0E] = 32'hE582E000; // STR R14,[R2]
    imem[6'h0F] = 32'hE5824008; // STR R4,[R2,#8]
    imem[6'h10] = 32'h03A06007; // MOVEQ R6,#7
    imem[6'h11] = 32'hE5826010; // STR R6,[R2,#16]
    imem[6'h12] = 32'hE2507001; // SUBS R7,R0,#1
    imem[6'h13] = 32'h43A08009; // MOVMI R8,#9
    imem[6'h14] = 32'h23A08003; // MOVCS R8,#3
    imem[6'h15] = 32'hE5828000; // STR R8,[R2]
    imem[6'h16] = 32'hE28F9000; // ADD R9,PC,#0
    imem[6'h17] = 32'hE5829000; // STR R9,[R2]
    imem[6'h18] = 32'hE1A0F00E; // MOV PC,R14

    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("reset_pc", PC, 32'h0);
    chk("reset_mw", {31'd0, MemWrite}, 32'h0);
    @(negedge clk);
    chk("held_reset_pc", PC, 32'h0);
    reset = 1'b1;
    #1 chk("release_pc0", PC, 32'h0);
    step(); chk("release_pc4", PC, 32'h4);
    step(); chk("release_pc8", PC, 32'h8);
    chk("str_mw_first", {31'd0, MemWrite}, 32'h1);

    // Asynchronous reset in the middle of a cycle.
    reset = 1'b0;
    #1;
    chk("midrun_reset_pc", PC, 32'h0);
    chk("midrun_reset_mw", {31'd0, MemWrite}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rerelease_pc0", PC, 32'h0);

    step(); chk("add_pc", PC, 32'h4);
    chk("add_alu", DataAddr, 32'h8);
    step(); chk("str_addr", DataAddr, 32'd20);
    chk("str_wdata", WriteData, 32'h8);
    chk("str_mw", {31'd0, MemWrite}, 32'h1);
    step(); chk("ldr_addr", DataAddr, 32'h4);
    chk("ldr_mw", {31'd0, MemWrite}, 32'h0);
    step(); chk("ldr_use_r3", DataAddr, 32'h23);
    step(); chk("cmp_result", DataAddr, 32'h0);
    step(); chk("beq_pc", PC, 32'h18);
    step(); chk("beq_taken_pc", PC, 32'h24);
    step(); chk("bl_target_pc", PC, 32'h2C);
    step(); chk("strne_pc", PC, 32'h30);
    chk("strne_mw", {31'd0, MemWrite}, 32'h0);
    step(); chk("bne_pc", PC, 32'h34);
    step(); chk("bne_not_taken_pc", PC, 32'h38);
    chk("lr_wdata", WriteData, 32'h28);
    chk("lr_mw", {31'd0, MemWrite}, 32'h1);
    step(); chk("subs_r4_wdata", WriteData, 32'h0);
    chk("subs_r4_addr", DataAddr, 32'h8);
    step();
    step(); chk("moveq_r6_wdata", WriteData, 32'h7);
    step(); chk("subs_r7_alu", DataAddr, 32'h22);
    step();
    step();
    step(); chk("movcs_r8_wdata", WriteData, 32'h3);
    step(); chk("pc_operand_alu", DataAddr, 32'h60);
    step(); chk("pc_operand_wdata", WriteData, 32'h60);
    step(); chk("mov_pc_pc", PC, 32'h60);
    step(); chk("mov_pc_target", PC, 32'h28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
